// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: control-byte layout,
// per-channel control flags and width limits.
package timer_pkg;

  // Bit positions of the control flags inside the 64-bit write word (byte 3).
  localparam int B3_ENA   = 31;
  localparam int B3_AR    = 30;
  localparam int B3_SEL   = 29;
  localparam int B3_IE    = 28;
  localparam int B3_IPCLR = 27;

  // Upper bounds for the prescaler and tick-counter widths.
  localparam int MAX_SW = 24;
  localparam int MAX_CW = 32;

  // Per-channel control/status flags.
  typedef struct packed {
    logic ena;
    logic ar;
    logic sel;
    logic ie;
    logic ip;
  } chan_ctrl_t;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: prescaler, tick counter, control flags and interrupt
// pending. Optional capture input when TIMER_CAPTURE_EN is defined.
module timer_chan
  import timer_pkg::*;
#(
  parameter int SW   = 24,
  parameter int CW   = 32,
  parameter int IDIV = 7
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          wr,
  input  logic [7:0]    BE,
  input  logic [63:0]   DI,
`ifdef TIMER_CAPTURE_EN
  input  logic          capt,
  output logic [CW-1:0] capr,
`endif
  output logic          intr,
  output logic          ena,
  output logic          ar,
  output logic          sel,
  output logic [SW-1:0] sclr,
  output logic [CW-1:0] tcnt
);

  // Low IDIV bits of the tick counter must be all ones for an event to interrupt.
  localparam logic [CW-1:0] IMASK = CW'((64'd1 << IDIV) - 64'd1);

  chan_ctrl_t        ctrl;
  logic [SW-1:0]     scaler;
  logic [SW-1:0]     ccnt;
  logic              term;
  logic              hit_q;
  logic              cap_rise;
  logic              sc_wr;
  logic              tc_wr;
  logic              b3_wr;
  logic [MAX_SW-1:0] sc_new;
  logic [MAX_CW-1:0] tc_new;
  logic              unused_di;

  assign unused_di = ^DI[26:24];

  assign sc_wr = wr & ~(&BE[2:0]);
  assign tc_wr = wr & ~(&BE[7:4]);
  assign b3_wr = wr & ~BE[3];
  assign term  = ctrl.ena & (ccnt == scaler);

  // Byte-merge of the write data into the current scaler and tick counter.
  always_comb begin
    sc_new = MAX_SW'(scaler);
    tc_new = MAX_CW'(tcnt);
    for (int i = 0; i < 3; i++)
      if (!BE[i]) sc_new[8*i +: 8] = DI[8*i +: 8];
    for (int i = 0; i < 4; i++)
      if (!BE[4+i]) tc_new[8*i +: 8] = DI[32+8*i +: 8];
  end

  // Scaler register and prescaler count; a scaler write restarts the count.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      scaler <= '0;
      ccnt   <= '0;
    end else begin
      if (sc_wr) scaler <= sc_new[SW-1:0];
      if (sc_wr || term) ccnt <= '0;
      else if (ctrl.ena) ccnt <= ccnt + SW'(1);
    end
  end

  // Tick counter; a byte write overrides a coincident increment.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)    tcnt <= '0;
    else if (tc_wr) tcnt <= tc_new[CW-1:0];
    else if (term)  tcnt <= tcnt + CW'(1);
  end

  // Control flags, one-shot auto-disable and interrupt pending (set beats clear).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ctrl  <= '0;
      hit_q <= 1'b0;
    end else begin
      hit_q <= term & (&(tcnt | ~IMASK));
      if (b3_wr) begin
        ctrl.ena <= DI[B3_ENA];
        ctrl.ar  <= DI[B3_AR];
        ctrl.sel <= DI[B3_SEL];
        ctrl.ie  <= DI[B3_IE];
      end else if (term && !ctrl.ar) begin
        ctrl.ena <= 1'b0;
      end
      if (hit_q || cap_rise)          ctrl.ip <= 1'b1;
      else if (b3_wr && DI[B3_IPCLR]) ctrl.ip <= 1'b0;
    end
  end

  // Registered view of either the scaler or the running prescaler count.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) sclr <= '0;
    else        sclr <= ctrl.sel ? scaler : ccnt;
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0] capt_s;

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) capt_s <= '0;
    else        capt_s <= {capt_s[1:0], capt};
  end

  assign cap_rise = capt_s[1] & ~capt_s[2];

  // Snapshot the tick counter on each synchronised capture edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)        capr <= '0;
    else if (cap_rise) capr <= tcnt;
  end
`else
  assign cap_rise = 1'b0;
`endif

  assign intr = ctrl.ip & ctrl.ie;
  assign ena  = ctrl.ena;
  assign ar   = ctrl.ar;
  assign sel  = ctrl.sel;

endmodule

// File: rtl/multi_timer.sv
// NCH independent timer channels behind a single 64-bit byte-enabled write
// port. Define TIMER_CAPTURE_EN to add per-channel capture inputs/registers.
module multi_timer
  import timer_pkg::*;
#(
  parameter  int NCH  = 4,
  parameter  int SW   = 24,
  parameter  int CW   = 32,
  parameter  int IDIV = 7,
  localparam int AW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ACT,
  input  logic [AW-1:0]     ADDR,
  input  logic [7:0]        BE,
  input  logic [63:0]       DI,
`ifdef TIMER_CAPTURE_EN
  input  logic [NCH-1:0]    CAPT,
  output logic [NCH*CW-1:0] CAPR,
`endif
  output logic [NCH-1:0]    INTR,
  output logic [NCH-1:0]    ENA,
  output logic [NCH-1:0]    AR,
  output logic [NCH-1:0]    SEL,
  output logic [NCH*SW-1:0] SCLR,
  output logic [NCH*CW-1:0] TCNTR
);

  logic [NCH-1:0]         wr;
  logic [NCH-1:0][SW-1:0] sclr_a;
  logic [NCH-1:0][CW-1:0] tcnt_a;
`ifdef TIMER_CAPTURE_EN
  logic [NCH-1:0][CW-1:0] capr_a;
  assign CAPR = capr_a;
`endif

  assign SCLR  = sclr_a;
  assign TCNTR = tcnt_a;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    // Out-of-range addresses never match any channel index.
    assign wr[k] = ACT & (ADDR == AW'(k));

    timer_chan #(.SW(SW), .CW(CW), .IDIV(IDIV)) u_chan (
      .CLK   (CLK),
      .RESET (RESET),
      .wr    (wr[k]),
      .BE    (BE),
      .DI    (DI),
`ifdef TIMER_CAPTURE_EN
      .capt  (CAPT[k]),
      .capr  (capr_a[k]),
`endif
      .intr  (INTR[k]),
      .ena   (ENA[k]),
      .ar    (AR[k]),
      .sel   (SEL[k]),
      .sclr  (sclr_a[k]),
      .tcnt  (tcnt_a[k])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed vector table, reset and
// capture sequences, then randomized writes against a reference model.
module tb_multi_timer;

  localparam int NCH  = 5;
  localparam int SW   = 24;
  localparam int CW   = 32;
  localparam int IDIV = 7;
  localparam int AW   = 3;

  logic              CLK;
  logic              RESET;
  logic              ACT;
  logic [AW-1:0]     ADDR;
  logic [7:0]        BE;
  logic [63:0]       DI;
  logic [NCH-1:0]    INTR, ENA, AR, SEL;
  logic [NCH*SW-1:0] SCLR;
  logic [NCH*CW-1:0] TCNTR;
`ifdef TIMER_CAPTURE_EN
  logic [NCH-1:0]    CAPT;
  logic [NCH*CW-1:0] CAPR;
`endif

  multi_timer #(.NCH(NCH), .SW(SW), .CW(CW), .IDIV(IDIV)) dut (
    .CLK(CLK), .RESET(RESET), .ACT(ACT), .ADDR(ADDR), .BE(BE), .DI(DI),
`ifdef TIMER_CAPTURE_EN
    .CAPT(CAPT), .CAPR(CAPR),
`endif
    .INTR(INTR), .ENA(ENA), .AR(AR), .SEL(SEL), .SCLR(SCLR), .TCNTR(TCNTR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_tc[NCH], m_capr[NCH];
  logic [23:0] m_sc[NCH], m_cc[NCH], m_sclr[NCH];
  bit          m_ena[NCH], m_ar[NCH], m_sel[NCH], m_ie[NCH], m_ip[NCH], m_hit[NCH];
  bit [2:0]    m_cs[NCH];

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_tc[c] = 0; m_capr[c] = 0; m_sc[c] = 0; m_cc[c] = 0; m_sclr[c] = 0;
      m_ena[c] = 0; m_ar[c] = 0; m_sel[c] = 0; m_ie[c] = 0; m_ip[c] = 0;
      m_hit[c] = 0; m_cs[c] = 0;
    end
  endtask

  function automatic logic [63:0] bytemask(input logic [7:0] be);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = be[i] ? 8'h00 : 8'hFF;
    return m;
  endfunction

  // One clock edge of every channel, from the pre-edge inputs.
  task automatic m_step(input logic act, input logic [AW-1:0] addr,
                        input logic [7:0] be, input logic [63:0] di);
    logic [63:0] bm;
    logic [23:0] scm;
    logic [31:0] tcm;
    longint unsigned period;
    bm  = bytemask(be);
    scm = bm[23:0];
    tcm = bm[63:32];
    period = 64'd1 << IDIV;
    for (int c = 0; c < NCH; c++) begin
      bit w, term, b3, cap;
      w    = act && (int'(addr) == c);
      term = m_ena[c] && (m_cc[c] == m_sc[c]);
      b3   = w && !be[3];
      cap  = 0;
`ifdef TIMER_CAPTURE_EN
      cap = m_cs[c][1] && !m_cs[c][2];
      if (cap) m_capr[c] = m_tc[c];
      m_cs[c] = {m_cs[c][1:0], CAPT[c]};
`endif
      m_sclr[c] = m_sel[c] ? m_sc[c] : m_cc[c];
      if (m_hit[c] || cap)   m_ip[c] = 1;
      else if (b3 && di[27]) m_ip[c] = 0;
      m_hit[c] = term && ((longint'(m_tc[c]) % period) == period - 1);
      if (w && scm != 0) begin
        m_sc[c] = (m_sc[c] & ~scm) | (di[23:0] & scm);
        m_cc[c] = 0;
      end else if (term)  m_cc[c] = 0;
      else if (m_ena[c])  m_cc[c] = m_cc[c] + 1;
      if (w && tcm != 0) m_tc[c] = (m_tc[c] & ~tcm) | (di[63:32] & tcm);
      else if (term)     m_tc[c] = m_tc[c] + 1;
      if (b3) begin
        m_ena[c] = di[31]; m_ar[c] = di[30]; m_sel[c] = di[29]; m_ie[c] = di[28];
      end else if (term && !m_ar[c]) m_ena[c] = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic check_model();
    logic [NCH*CW-1:0] e_tc, e_cap;
    logic [NCH*SW-1:0] e_sc;
    logic [NCH-1:0]    e_ena, e_ar, e_sel, e_int;
    for (int c = 0; c < NCH; c++) begin
      e_tc[c*CW +: CW]  = m_tc[c];
      e_cap[c*CW +: CW] = m_capr[c];
      e_sc[c*SW +: SW]  = m_sclr[c];
      e_ena[c] = m_ena[c]; e_ar[c] = m_ar[c]; e_sel[c] = m_sel[c];
      e_int[c] = m_ip[c] & m_ie[c];
    end
    chk("mdl_tcntr", 256'(TCNTR), 256'(e_tc));
    chk("mdl_flags", 256'({ENA, AR, SEL}), 256'({e_ena, e_ar, e_sel}));
    chk("mdl_sclr",  256'(SCLR), 256'(e_sc));
    chk("mdl_intr",  256'(INTR), 256'(e_int));
`ifdef TIMER_CAPTURE_EN
    chk("mdl_capr",  256'(CAPR), 256'(e_cap));
`endif
  endtask

  task automatic cyc(input logic act, input logic [AW-1:0] addr,
                     input logic [7:0] be, input logic [63:0] di);
    ACT = act; ADDR = addr; BE = be; DI = di;
    @(posedge CLK);
    m_step(act, addr, be, di);
    #1;
    check_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          act;
    logic [AW-1:0] addr;
    logic [7:0]    be;
    logic [63:0]   di;
    int            ch;
    logic [31:0]   tc;
    logic          ena;
    logic [23:0]   sclr;
    logic          intr;
  } vec_t;

  vec_t tbl[24];

  initial begin
    // periodic scaler=3 on ch0
    tbl[0]  = '{1'b1, 3'd0, 8'h00, 64'h00000000_C0000003, 0, 32'h0, 1'b1, 24'd0, 1'b0};
    tbl[1]  = '{1'b0, 3'd0, 8'hFF, 64'h0, 0, 32'h0, 1'b1, 24'd0, 1'b0};
    tbl[2]  = '{1'b0, 3'd0, 8'hFF, 64'h0, 0, 32'h0, 1'b1, 24'd1, 1'b0};
    tbl[3]  = '{1'b0, 3'd0, 8'hFF, 64'h0, 0, 32'h0, 1'b1, 24'd2, 1'b0};
    tbl[4]  = '{1'b0, 3'd0, 8'hFF, 64'h0, 0, 32'h1, 1'b1, 24'd3, 1'b0};
    tbl[5]  = '{1'b0, 3'd0, 8'hFF, 64'h0, 0, 32'h1, 1'b1, 24'd0, 1'b0};
    tbl[6]  = '{1'b0, 3'd0, 8'hFF, 64'h0, 0, 32'h1, 1'b1, 24'd1, 1'b0};
    tbl[7]  = '{1'b0, 3'd0, 8'hFF, 64'h0, 0, 32'h1, 1'b1, 24'd2, 1'b0};
    tbl[8]  = '{1'b0, 3'd0, 8'hFF, 64'h0, 0, 32'h2, 1'b1, 24'd3, 1'b0};
    // one-shot scaler=2 on ch1
    tbl[9]  = '{1'b1, 3'd1, 8'h00, 64'h00000000_80000002, 1, 32'h0, 1'b1, 24'd0, 1'b0};
    tbl[10] = '{1'b0, 3'd0, 8'hFF, 64'h0, 1, 32'h0, 1'b1, 24'd0, 1'b0};
    tbl[11] = '{1'b0, 3'd0, 8'hFF, 64'h0, 1, 32'h0, 1'b1, 24'd1, 1'b0};
    tbl[12] = '{1'b0, 3'd0, 8'hFF, 64'h0, 1, 32'h1, 1'b0, 24'd2, 1'b0};
    tbl[13] = '{1'b0, 3'd0, 8'hFF, 64'h0, 1, 32'h1, 1'b0, 24'd0, 1'b0};
    tbl[14] = '{1'b0, 3'd0, 8'hFF, 64'h0, 1, 32'h1, 1'b0, 24'd0, 1'b0};
    // wrap + interrupt + IP clear on ch2 (scaler 0, every cycle)
    tbl[15] = '{1'b1, 3'd2, 8'h00, 64'hFFFFFFFF_D0000000, 2, 32'hFFFFFFFF, 1'b1, 24'd0, 1'b0};
    tbl[16] = '{1'b0, 3'd0, 8'hFF, 64'h0, 2, 32'h0, 1'b1, 24'd0, 1'b0};
    tbl[17] = '{1'b0, 3'd0, 8'hFF, 64'h0, 2, 32'h1, 1'b1, 24'd0, 1'b1};
    tbl[18] = '{1'b1, 3'd2, 8'hF7, 64'h00000000_D8000000, 2, 32'h2, 1'b1, 24'd0, 1'b0};
    tbl[19] = '{1'b1, 3'd2, 8'hF7, 64'h0, 2, 32'h3, 1'b0, 24'd0, 1'b0};
    // partial tick-counter write coincident with a terminal event on ch3
    tbl[20] = '{1'b1, 3'd3, 8'h00, 64'h000100FF_80000001, 3, 32'h000100FF, 1'b1, 24'd0, 1'b0};
    tbl[21] = '{1'b0, 3'd0, 8'hFF, 64'h0, 3, 32'h000100FF, 1'b1, 24'd0, 1'b0};
    tbl[22] = '{1'b1, 3'd3, 8'hCF, 64'h0000ABCD_00000000, 3, 32'h0001ABCD, 1'b0, 24'd1, 1'b0};
    // out-of-range address touches nothing
    tbl[23] = '{1'b1, 3'd5, 8'h00, 64'hFFFFFFFF_FFFFFFFF, 3, 32'h0001ABCD, 1'b0, 24'd0, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [63:0] di;
    logic [7:0]  be;
    RESET = 1'b0; ACT = 1'b0; ADDR = '0; BE = 8'hFF; DI = '0;
`ifdef TIMER_CAPTURE_EN
    CAPT = '0;
`endif
    m_reset();
    #3;
    chk("rst_tcntr", 256'(TCNTR), 256'(0));
    chk("rst_flags", 256'({ENA, AR, SEL, INTR}), 256'(0));
    chk("rst_sclr",  256'(SCLR), 256'(0));
    @(posedge CLK); #1;
    RESET = 1'b1;

    for (int r = 0; r < 24; r++) begin
      cyc(tbl[r].act, tbl[r].addr, tbl[r].be, tbl[r].di);
      chk($sformatf("tbl%0d_tcnt", r), 256'(TCNTR[tbl[r].ch*CW +: CW]), 256'(tbl[r].tc));
      chk($sformatf("tbl%0d_ena", r),  256'(ENA[tbl[r].ch]), 256'(tbl[r].ena));
      chk($sformatf("tbl%0d_sclr", r), 256'(SCLR[tbl[r].ch*SW +: SW]), 256'(tbl[r].sclr));
      chk($sformatf("tbl%0d_intr", r), 256'(INTR[tbl[r].ch]), 256'(tbl[r].intr));
    end

    // asynchronous reset in the middle of counting
    RESET = 1'b0;
    #2;
    chk("midrst_tcntr", 256'(TCNTR), 256'(0));
    chk("midrst_flags", 256'({ENA, AR, SEL, INTR}), 256'(0));
    chk("midrst_sclr",  256'(SCLR), 256'(0));
    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    cyc(1'b0, '0, 8'hFF, 64'h0);

`ifdef TIMER_CAPTURE_EN
    // capture on ch1 while its counter holds 0x10
    cyc(1'b1, 3'd1, 8'h00, 64'h00000010_10000000);
    CAPT[1] = 1'b1;
    cyc(1'b0, '0, 8'hFF, 64'h0);
    CAPT[1] = 1'b0;
    cyc(1'b0, '0, 8'hFF, 64'h0);
    cyc(1'b0, '0, 8'hFF, 64'h0);
    chk("cap_capr1", 256'(CAPR[CW +: CW]), 256'(32'h10));
    chk("cap_intr1", 256'(INTR[1]), 256'(1));
`endif

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      di = {$urandom, $urandom};
      be = 8'($urandom);
      if ($urandom_range(0, 3) == 0) be = 8'h00;
      if ($urandom_range(0, 3) != 0) di[23:0] = 24'($urandom_range(0, 6));
      if ($urandom_range(0, 1) == 1) di[38:32] = 7'h7F;
      if ($urandom_range(0, 15) == 0) di[63:32] = 32'hFFFFFFFF;
      di[31] = ($urandom_range(0, 3) != 0);
`ifdef TIMER_CAPTURE_EN
      CAPT = NCH'($urandom);
`endif
      cyc($urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)), be, di);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
